mc_ctrl_fsm: RTL and testbench

- Multicycle main controller for the MIPS-subset CPU.
- Sequences fetch, decode, execute, memory and writeback over a shared ALU and a single unified memory port.
- Drives the 2-bit ALUOp consumed by the ALU-control decoder, plus all datapath mux and write enables.
- Stretches memory states on a ready handshake and traps illegal opcodes.

---
 rtl/mc_ctrl_fsm.sv | 182 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main controller for the MIPS-subset CPU: sequences fetch, decode,
// execute, memory and writeback over a shared ALU and one unified memory port.
module mc_ctrl_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2b,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       mem_req,
    output logic       mem_we,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_REX   = 4'd6,
        S_RWB   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9,
        S_TRAP  = 4'd15
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       illegal_q, illegal_d;
    ctrl_t      ctrl;

    // The branch decision is made in the datapath; the flag only documents the interface.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        ctrl      = '0;
        case (state_q)
            S_IF: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                ctrl.alu_src_b = 2'b11;
                op_d           = opcode;
                if (opcode == OP_LW || opcode == OP_SW) state_d = S_MADDR;
                else if (opcode == OP_RTYPE)            state_d = S_REX;
                else if (opcode == OP_BEQ)              state_d = S_BR;
                else if (opcode == OP_J)                state_d = S_JMP;
                else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_MADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_d        = (op_q == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem_ready) state_d = S_MWB;
            end
            S_MWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_IF;
            end
            S_MWR: begin
                ctrl.mem_req    = 1'b1;
                ctrl.mem_we     = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
                if (mem_ready) state_d = S_IF;
            end
            S_REX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 2'b10;
                state_d        = S_RWB;
            end
            S_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_IF;
            end
            S_BR: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
                ctrl.instr_done    = 1'b1;
                state_d            = S_IF;
            end
            S_JMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = 2'b10;
                ctrl.instr_done = 1'b1;
                state_d         = S_IF;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    // While reset is asserted nothing leaves the block, even mid-instruction.
    assign mem_req     = rst_n & ctrl.mem_req;
    assign mem_we      = rst_n & ctrl.mem_we;
    assign IorD        = rst_n & ctrl.iord;
    assign IRWrite     = rst_n & ctrl.ir_write;
    assign PCWrite     = rst_n & ctrl.pc_write;
    assign PCWriteCond = rst_n & ctrl.pc_write_cond;
    assign PCSource    = rst_n ? ctrl.pc_source : 2'b00;
    assign ALUSrcA     = rst_n & ctrl.alu_src_a;
    assign ALUSrcB     = rst_n ? ctrl.alu_src_b : 2'b00;
    assign ALUOp       = rst_n ? ctrl.alu_op : 2'b00;
    assign RegDst      = rst_n & ctrl.reg_dst;
    assign MemtoReg    = rst_n & ctrl.mem_to_reg;
    assign RegWrite    = rst_n & ctrl.reg_write;
    assign instr_done  = rst_n & ctrl.instr_done;
    assign illegal_op  = rst_n & illegal_q;
    assign state       = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: each instruction is expanded into its
// expected cycle-by-cycle state walk and compared against the DUT outputs.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       zero;
    logic       mem_req, mem_we, IorD, IRWrite, PCWrite, PCWriteCond;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic       ALUSrcA, RegDst, MemtoReg, RegWrite, instr_done, illegal_op;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .instr_done(instr_done),
        .illegal_op(illegal_op), .state(state)
    );

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;
        logic [3:0] state;
    } obs_t;

    obs_t obs;
    assign obs = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
                  ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, instr_done,
                  illegal_op, state};

    typedef struct {
        int   code;
        logic rdy;
    } step_t;

    step_t plan[$];

    localparam int C_IF = 0, C_ID = 1, C_MADDR = 2, C_MRD = 3, C_MWB = 4, C_MWR = 5;
    localparam int C_REX = 6, C_RWB = 7, C_BR = 8, C_JMP = 9, C_TRAP = 15;

    // Output table written straight from the per-state behaviour description.
    function automatic obs_t exp_of(int code, logic rdy);
        obs_t e = '0;
        e.state = 4'(code);
        case (code)
            C_IF: begin
                e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy;
            end
            C_ID:    e.alu_src_b = 2'b11;
            C_MADDR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            C_MRD:   begin e.mem_req = 1; e.iord = 1; end
            C_MWB:   begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
            C_MWR:   begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; e.instr_done = rdy; end
            C_REX:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            C_RWB:   begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
            C_BR: begin
                e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
                e.pc_source = 2'b01; e.instr_done = 1;
            end
            C_JMP:   begin e.pc_write = 1; e.pc_source = 2'b10; e.instr_done = 1; end
            C_TRAP:  e.illegal_op = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic void push(int code, logic rdy);
        step_t s;
        s.code = code;
        s.rdy  = rdy;
        plan.push_back(s);
    endfunction

    // Expand one instruction into its expected walk; stall cycles keep mem_ready low.
    function automatic void build(logic [5:0] op, int f, int m);
        plan.delete();
        for (int i = 0; i < f; i++) push(C_IF, 1'b0);
        push(C_IF, 1'b1);
        push(C_ID, 1'($urandom));
        case (op)
            6'h00: begin push(C_REX, 1'($urandom)); push(C_RWB, 1'($urandom)); end
            6'h23: begin
                push(C_MADDR, 1'($urandom));
                for (int i = 0; i < m; i++) push(C_MRD, 1'b0);
                push(C_MRD, 1'b1);
                push(C_MWB, 1'($urandom));
            end
            6'h2b: begin
                push(C_MADDR, 1'($urandom));
                for (int i = 0; i < m; i++) push(C_MWR, 1'b0);
                push(C_MWR, 1'b1);
            end
            6'h04: push(C_BR, 1'($urandom));
            6'h02: push(C_JMP, 1'($urandom));
            default: for (int i = 0; i < 10; i++) push(C_TRAP, 1'($urandom));
        endcase
    endfunction

    function automatic int latency_of(logic [5:0] op, int f, int m);
        case (op)
            6'h23:   return 5 + f + m;
            6'h2b:   return 4 + f + m;
            6'h00:   return 4 + f;
            default: return 3 + f;
        endcase
    endfunction

    task automatic run_plan(input logic [5:0] op, input string name,
                            output int done_cnt, output int done_at);
        obs_t e;
        done_cnt = 0;
        done_at  = 0;
        for (int i = 0; i < plan.size(); i++) begin
            @(negedge clk);
            mem_ready = plan[i].rdy;
            // After decode the live opcode is garbage; only the latched copy may matter.
            opcode = (plan[i].code <= C_ID) ? op : 6'($urandom);
            zero   = 1'($urandom);
            #1;
            e = exp_of(plan[i].code, plan[i].rdy);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s step %0d: got %h expected %h (state %0d vs %0d)",
                         name, i, obs, e, obs.state, e.state);
            end
            if (obs.instr_done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = i + 1;
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int f, input int m, input string name);
        int done_cnt, done_at, lat;
        build(op, f, m);
        run_plan(op, name, done_cnt, done_at);
        lat = latency_of(op, f, m);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
        end
        checks++;
        if (done_at !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, done_at, lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'h00; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h expected 0", i, obs);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== exp_of(C_IF, 1'b0)) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs, exp_of(C_IF, 1'b0));
        end
    endtask

    task automatic test_rtype();         run_instr(6'h00, 0, 0, "rtype");      endtask
    task automatic test_lw_stall();      run_instr(6'h23, 0, 2, "lw_stall");   endtask
    task automatic test_fetch_stall_j(); run_instr(6'h02, 4, 0, "fetch_j");    endtask

    task automatic test_back_to_back();
        run_instr(6'h2b, 0, 0, "b2b_sw");
        run_instr(6'h04, 0, 0, "b2b_beq");
        run_instr(6'h2b, 0, 1, "b2b_sw_stall");
    endtask

    task automatic test_random();
        logic [5:0] ops [5];
        logic [5:0] op;
        int f, m;
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02};
        for (int n = 0; n < 25; n++) begin
            op = ops[$urandom_range(0, 4)];
            f  = $urandom_range(0, 3);
            m  = $urandom_range(0, 3);
            run_instr(op, f, m, $sformatf("rand%0d_op%h", n, op));
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk); mem_ready = 1'b1; opcode = 6'h23;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); opcode = 6'h3f;
        @(negedge clk); mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 4'd3) begin
            errors++;
            $display("FAIL mid_reset_setup: got state %0d expected 3", state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL mid_reset_gate: got %h expected 0", obs);
        end
        @(negedge clk); #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL mid_reset_hold: got %h expected 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== exp_of(C_IF, 1'b0)) begin
            errors++;
            $display("FAIL mid_reset_release: got %h expected %h", obs, exp_of(C_IF, 1'b0));
        end
    endtask

    task automatic test_trap();
        int done_cnt, done_at;
        build(6'h3f, 0, 0);
        run_plan(6'h3f, "trap", done_cnt, done_at);
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL trap_done: got %0d pulses expected 0", done_cnt);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL trap_reset: got %h expected 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== exp_of(C_IF, 1'b0)) begin
            errors++;
            $display("FAIL trap_release: got %h expected %h", obs, exp_of(C_IF, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_back_to_back();
        test_fetch_stall_j();
        test_random();
        test_mid_reset();
        test_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
